// File: rtl/cic_pkg.sv
// Shared constants and width helpers for the CIC decimator and the ISOP stage
// that consumes its output.
package cic_pkg;

  localparam int CIC_IN_W     = 8;
  localparam int CIC_OUT_W    = 8;
  localparam int CIC_N_STAGES = 3;
  localparam int CIC_R        = 8;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int p = 1; p < value; p = p * 2) begin
      result = result + 1;
    end
    return result;
  endfunction

  // Bit growth of N stages at ratio R (M=1) is N*log2(R) above the input width.
  function automatic int acc_width(input int in_w, input int n_stages, input int r);
    return in_w + n_stages * clog2(r);
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC comb section: y = x - x_prev, where x_prev only advances on decimated
// sample strobes.
module cic_comb_stage #(
  parameter int W = 17
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic signed [W-1:0] x,
  output logic signed [W-1:0] y
);

  logic signed [W-1:0] dly;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dly <= '0;
    end else if (en) begin
      dly <= x;
    end
  end

  assign y = x - dly;

endmodule

// File: rtl/cic_decimator.sv
// N-stage CIC decimator (M=1): pipelined integrators at the input rate, decimate
// by R, combinational comb chain at the output rate, truncated to OUT_W bits.
module cic_decimator
  import cic_pkg::*;
#(
  parameter int IN_W     = CIC_IN_W,
  parameter int OUT_W    = CIC_OUT_W,
  parameter int N_STAGES = CIC_N_STAGES,
  parameter int R        = CIC_R
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [IN_W-1:0]  d_in,
  input  logic                    in_valid,
  output logic signed [OUT_W-1:0] d_out,
  output logic                    out_valid
);

  localparam int ACC_W = acc_width(IN_W, N_STAGES, R);
  localparam int CNT_W = clog2(R);

  logic signed [ACC_W-1:0] d_ext;
  logic signed [ACC_W-1:0] integ [N_STAGES];
  logic        [CNT_W-1:0] cnt;
  logic signed [ACC_W-1:0] dec_sample;
  logic                    dec_valid;
  logic signed [ACC_W-1:0] comb_chain [N_STAGES+1];
  logic signed [ACC_W-1:0] comb_out;

  assign d_ext = {{(ACC_W-IN_W){d_in[IN_W-1]}}, d_in};

  // Integrators wrap modulo 2^ACC_W; the combs undo the wrap exactly.
  for (genvar k = 0; k < N_STAGES; k++) begin : g_integ
    logic signed [ACC_W-1:0] acc;
    if (k == 0) begin : g_first
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          acc <= '0;
        end else if (in_valid) begin
          acc <= acc + d_ext;
        end
      end
    end else begin : g_rest
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          acc <= '0;
        end else if (in_valid) begin
          acc <= acc + integ[k-1];
        end
      end
    end
    assign integ[k] = acc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      dec_sample <= '0;
      dec_valid  <= 1'b0;
    end else begin
      dec_valid <= 1'b0;
      if (in_valid) begin
        if (cnt == CNT_W'(R - 1)) begin
          cnt        <= '0;
          dec_sample <= integ[N_STAGES-1];
          dec_valid  <= 1'b1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  assign comb_chain[0] = dec_sample;

  for (genvar k = 0; k < N_STAGES; k++) begin : g_comb
    cic_comb_stage #(.W(ACC_W)) u_comb (
      .clk (clk),
      .rst (rst),
      .en  (dec_valid),
      .x   (comb_chain[k]),
      .y   (comb_chain[k+1])
    );
  end

  assign comb_out = comb_chain[N_STAGES];

  // Arithmetic shift keeps the top OUT_W bits, i.e. truncation toward -inf.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_out     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= dec_valid;
      if (dec_valid) begin
        d_out <= OUT_W'(comb_out >>> (ACC_W - OUT_W));
      end
    end
  end

endmodule

// File: tb/tb_cic_decimator.sv
// Self-checking bench for cic_decimator: DC vector table plus reset corner
// sequences, with a scoreboard of expected output pulses (cycle and value).
module tb_cic_decimator;

  localparam int N = 3;
  localparam int R = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic signed [7:0] d_in = '0;
  logic              in_valid = 1'b0;
  logic signed [7:0] d_out;
  logic              out_valid;

  cic_decimator #(.IN_W(8), .OUT_W(8), .N_STAGES(N), .R(R)) dut (
    .clk       (clk),
    .rst       (rst),
    .d_in      (d_in),
    .in_valid  (in_valid),
    .d_out     (d_out),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic signed [7:0] val;
    bit                chk;
    int                due;
  } exp_t;

  typedef struct {
    int val;
    bit gap;
    int samples;
    int pulses;
  } vec_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   accepted = 0;
  int   frames = 0;
  int   pulseCnt = 0;
  bit   strict = 1'b0;

  task automatic checkOutput(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Drive one cycle of input; every R-th accepted sample schedules an output pulse
  // two edges later (accepting edge, then the comb/output register edge).
  task automatic applyStimulus(input logic signed [7:0] v, input bit valid);
    exp_t e;
    @(posedge clk);
    #1;
    d_in     = v;
    in_valid = valid;
    if (valid) begin
      accepted++;
      if (accepted % R == 0) begin
        e.val = v;
        e.chk = strict || (frames >= N);
        e.due = cyc + 2;
        sbq.push_back(e);
        frames++;
      end
    end
  endtask

  task automatic drain(input int bound);
    int n;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    while (sbq.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      checkOutput("drain_timeout", sbq.size(), 0);
      sbq.delete();
    end
  endtask

  task automatic clearModel();
    sbq.delete();
    accepted = 0;
    frames   = 0;
    pulseCnt = 0;
  endtask

  task automatic resetDut();
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b1;
    d_in     = 8'sd77;
    clearModel();
    repeat (5) begin
      @(negedge clk);
      checkOutput("rst_d_out", d_out, 0);
      checkOutput("rst_out_valid", out_valid, 0);
    end
    @(posedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst && out_valid) begin
      pulseCnt++;
      if (sbq.size() == 0) begin
        checkOutput("unexpected_pulse", 1, 0);
      end else begin
        mon_e = sbq.pop_front();
        checkOutput("pulse_cycle", cyc, mon_e.due);
        if (mon_e.chk) checkOutput("d_out", d_out, mon_e.val);
      end
    end
  end

  initial begin
    #2_000_000;
    failures++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  vec_t vecs[5];

  initial begin
    // Wrap test uses 20000 samples: integ[2] wraps many times well before that.
    vecs[0] = '{val:   64, gap: 1'b0, samples:    80, pulses:   10};
    vecs[1] = '{val: -128, gap: 1'b0, samples:    80, pulses:   10};
    vecs[2] = '{val:   10, gap: 1'b1, samples:    48, pulses:    6};
    vecs[3] = '{val:  -37, gap: 1'b0, samples:    64, pulses:    8};
    vecs[4] = '{val:  127, gap: 1'b0, samples: 20000, pulses: 2500};

    // Reset with valid input held high, then no pulse before the R-th sample.
    resetDut();
    strict = 1'b0;
    repeat (R - 1) applyStimulus(8'sd77, 1'b1);
    repeat (4) applyStimulus(8'sd77, 1'b0);
    checkOutput("early_pulse", pulseCnt, 0);
    applyStimulus(8'sd77, 1'b1);
    drain(20);
    checkOutput("first_frame_pulses", pulseCnt, 1);

    for (int i = 0; i < 5; i++) begin
      resetDut();
      strict = 1'b0;
      for (int s = 0; s < vecs[i].samples; s++) begin
        applyStimulus(8'(vecs[i].val), 1'b1);
        if (vecs[i].gap) applyStimulus(8'(vecs[i].val), 1'b0);
      end
      drain(40);
      checkOutput($sformatf("vec%0d_pulses", i), pulseCnt, vecs[i].pulses);
      // in_valid low with a different d_in: output must hold, no pulses.
      repeat (40) applyStimulus(8'(-vecs[i].val - 1), 1'b0);
      checkOutput($sformatf("vec%0d_hold_d_out", i), d_out, vecs[i].val);
      checkOutput($sformatf("vec%0d_hold_pulses", i), pulseCnt, vecs[i].pulses);
    end

    // Mid-frame reset: nonzero history, reset after 5 samples of a frame.
    resetDut();
    strict = 1'b0;
    repeat (2 * R + 5) applyStimulus(8'sd50, 1'b1);
    @(posedge clk);
    #3;
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    checkOutput("async_rst_d_out", d_out, 0);
    checkOutput("async_rst_out_valid", out_valid, 0);
    clearModel();
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b1;
    strict = 1'b1;
    repeat (R) applyStimulus(8'sd0, 1'b1);
    drain(20);
    checkOutput("midrst_pulses", pulseCnt, 1);
    repeat (2 * R) applyStimulus(8'sd0, 1'b1);
    drain(20);
    checkOutput("midrst_total_pulses", pulseCnt, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
